wddl_dr_capture: RTL and testbench
==================================

// Module: wddl_dr_capture
// PURPOSE
//  Dual-rail-to-single-rail receiver at the output of a WDDL combinational cone (xor trees, sbox).
//  Drives the cone's precharge control and sequences precharge/evaluate.
//  Uses completion detection to capture the evaluated word as single-rail data.
//  Flags illegal (1,1) codes and stalls, and presents the result on a valid/ready interface.
// PARAMETERS
//  WIDTH     8   dual-rail word width (bits)
//  EVAL_CYC  2   minimum EVAL cycles before completion is accepted (early-propagation filter); >=1
//  TIMEOUT   15  max cycles allowed in EVAL or PRECHG before error; TIMEOUT >= EVAL_CYC
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  req_in        in   1      single-cycle request to evaluate one word
//  req_ack_out   out  1      pulse: request accepted (IDLE -> EVAL)
//  pre_out       out  1      registered precharge control to cone; 1 = precharge (forces spacer 00)
//  d_p_in        in   WIDTH  true rail from cone
//  d_n_in        in   WIDTH  complement rail from cone
//  q_out         out  WIDTH  captured single-rail word (= d_p_in at capture)
//  valid_out     out  1      q_out valid; held until ready_in
//  ready_in      in   1      downstream accepts q_out
//  busy_out      out  1      state != IDLE
//  err_out       out  1      one-cycle pulse on error
//  err_code_out  out  2      last error: 01 illegal 11, 10 eval timeout, 11 precharge timeout
// BEHAVIOUR
//  Per-bit decode (combinational, same cycle):
//   - spacer = p|n == 0 for all bits
//   - complete = p^n == 1 for all bits
//   - illegal = any bit with p&n
//  Reset (async, rst_n=0):
//   - state=IDLE, pre_out=1, q_out=0, valid_out=0, req_ack_out=0, err_out=0, err_code_out=00, cnt=0
//  States: IDLE, EVAL, PRECHG; cnt counts cycles spent in the current state.
//   IDLE:
//    - pre_out=1
//    - accept req_in iff spacer && (!valid_out || ready_in)
//    - on accept: req_ack_out=1, next EVAL (pre_out=0 from next cycle), cnt=0
//    - req_in ignored (dropped, no ack) otherwise
//   EVAL:
//    - illegal in any EVAL cycle -> err code 01, next PRECHG, no capture
//    - else complete && cnt>=EVAL_CYC-1 -> capture next edge (q_out=d_p_in, valid_out=1), next PRECHG
//    - else cnt==TIMEOUT-1 -> err code 10, next PRECHG
//    - illegal has priority over complete
//   PRECHG:
//    - pre_out=1
//    - spacer -> IDLE
//    - illegal -> err code 01, stay
//    - cnt==TIMEOUT-1 without spacer -> err code 11, cnt restarts, stay
//  Latency: req accepted at cycle 0 -> earliest valid_out at cycle EVAL_CYC+1.
//  valid_out/ready_in:
//   - q_out stable while valid_out && !ready_in
//   - valid_out clears the cycle after ready_in=1
//   - a capture coinciding with ready_in reloads q_out, keeps valid_out=1
//  err_out: pulses once per error event; err_code_out holds until next error or reset.
//  Reset mid-EVAL: pre_out returns to 1 asynchronously; partial word discarded.
// TESTING (WIDTH=8, EVAL_CYC=2, TIMEOUT=6)
//  T1 reset: rst_n=0 mid-EVAL -> pre_out=1 immediately, valid_out=0, q_out=00, err_code_out=00
//  T2 normal: spacer, req at c0; p=A5/n=5A from c2 -> req_ack c0, pre_out=0 c1-c2, valid_out=1 q_out=A5 c3; ready_in low 4 cycles -> q_out stable
//  T3 early glitch filter: complete word at c1 (first EVAL cycle) -> ignored; capture still at c3
//  T4 illegal: bit3 p=n=1 at c2 -> err_out pulse, err_code_out=01, valid_out stays 0, pre_out=1 at c3
//  T5 eval timeout: bit0 held 00 -> err_code_out=10 after 6 EVAL cycles, PRECHG, no valid
//  T6 precharge stall: word held non-spacer 6 cycles after capture -> err_code_out=11; req_in ignored until spacer; then back-to-back req with ready_in=1 -> second word captured without drop

Source files
------------

// File: rtl/wddl_dr_capture.sv
// ---------------------------------------------------------------------------
// wddl_dr_capture
//
// Dual-rail to single-rail receiver sitting at the output of a WDDL
// combinational cone. It owns the cone's precharge control, sequences
// precharge/evaluate, uses completion detection to capture the evaluated word
// and hands it downstream on a valid/ready interface. Illegal (1,1) rail codes
// and stalls in either phase are reported as error events.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   req_in        in   1      single-cycle request to evaluate one word
//   req_ack_out   out  1      same-cycle pulse: request accepted
//   pre_out       out  1      registered precharge control (1 = precharge)
//   d_p_in        in   WIDTH  true rail from cone
//   d_n_in        in   WIDTH  complement rail from cone
//   q_out         out  WIDTH  captured single-rail word
//   valid_out     out  1      q_out valid, held until ready_in
//   ready_in      in   1      downstream accepts q_out
//   busy_out      out  1      sequencer not idle
//   err_out       out  1      one-cycle pulse per error event
//   err_code_out  out  2      last error: 01 illegal, 10 eval timeout,
//                             11 precharge timeout
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | cone precharged, waiting for a request while rails show spacer
// EVAL   | precharge released, waiting for a complete, legal word
// PRECHG | precharge reasserted, waiting for rails to return to spacer
// ---------------------------------------------------------------------------
module wddl_dr_capture #(
    parameter int WIDTH    = 8,
    parameter int EVAL_CYC = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_in,
    output logic             req_ack_out,
    output logic             pre_out,
    input  logic [WIDTH-1:0] d_p_in,
    input  logic [WIDTH-1:0] d_n_in,
    output logic [WIDTH-1:0] q_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             busy_out,
    output logic             err_out,
    output logic [1:0]       err_code_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] CNT_TC   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_EVAL = CW'(EVAL_CYC - 1);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_EVAL_TO = 2'b10;
    localparam logic [1:0] ERR_PRE_TO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_PRECHG = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pre_q, pre_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    // -----------------------------------------------------------------------
    // Per-bit rail decode, combinational on the live cone outputs
    // -----------------------------------------------------------------------
    logic spacer, complete, illegal;

    always_comb begin
        spacer   = ((d_p_in | d_n_in) == '0);
        complete = ((d_p_in ^ d_n_in) == '1);
        illegal  = ((d_p_in & d_n_in) != '0);
    end

    logic cnt_tc, eval_min_met, out_free;

    always_comb begin
        cnt_tc       = (cnt_q == CNT_TC);
        eval_min_met = (cnt_q >= CNT_EVAL);
        // A new word may only be requested if the output slot is empty or
        // is being emptied this cycle, so a capture can never overwrite
        // an unconsumed word.
        out_free     = !valid_q || ready_in;
    end

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        data_d      = data_q;
        valid_d     = valid_q && !ready_in;
        err_d       = 1'b0;
        code_d      = code_q;
        req_ack_out = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_in && spacer && out_free) begin
                    req_ack_out = 1'b1;
                    state_d     = S_EVAL;
                end
            end

            S_EVAL: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ILLEGAL;
                    state_d = S_PRECHG;
                    cnt_d   = '0;
                end else if (complete && eval_min_met) begin
                    // Completion before EVAL_CYC cycles is treated as early
                    // propagation and ignored.
                    data_d  = d_p_in;
                    valid_d = 1'b1;
                    state_d = S_PRECHG;
                    cnt_d   = '0;
                end else if (cnt_tc) begin
                    err_d   = 1'b1;
                    code_d  = ERR_EVAL_TO;
                    state_d = S_PRECHG;
                    cnt_d   = '0;
                end
            end

            S_PRECHG: begin
                if (spacer) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (illegal) begin
                        err_d  = 1'b1;
                        code_d = ERR_ILLEGAL;
                    end else if (cnt_tc) begin
                        err_d  = 1'b1;
                        code_d = ERR_PRE_TO;
                    end
                    // Stall window restarts so a stuck cone reports once per
                    // TIMEOUT cycles rather than every cycle.
                    if (cnt_tc) begin
                        cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Precharge is released only while evaluating.
        pre_d = (state_d != S_EVAL);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        pre_out      = pre_q;
        q_out        = data_q;
        valid_out    = valid_q;
        busy_out     = (state_q != S_IDLE);
        err_out      = err_q;
        err_code_out = code_q;
    end

endmodule

// File: tb/tb_wddl_dr_capture.sv
module tb_wddl_dr_capture;

    localparam int W  = 8;
    localparam int EC = 2;
    localparam int TO = 6;

    logic         clk;
    logic         rst_n;
    logic         req_in;
    logic         req_ack_out;
    logic         pre_out;
    logic [W-1:0] d_p_in;
    logic [W-1:0] d_n_in;
    logic [W-1:0] q_out;
    logic         valid_out;
    logic         ready_in;
    logic         busy_out;
    logic         err_out;
    logic [1:0]   err_code_out;

    wddl_dr_capture #(.WIDTH(W), .EVAL_CYC(EC), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .req_ack_out  (req_ack_out),
        .pre_out      (pre_out),
        .d_p_in       (d_p_in),
        .d_n_in       (d_n_in),
        .q_out        (q_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .busy_out     (busy_out),
        .err_out      (err_out),
        .err_code_out (err_code_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] p, input logic [W-1:0] n);
        d_p_in = p;
        d_n_in = n;
    endtask

    // Transaction-level reference: given the rail words seen in each EVAL
    // cycle, decide which cycle ends the evaluation and how.
    localparam int K_CAP = 0;
    localparam int K_ILL = 1;
    localparam int K_TMO = 2;

    logic [W-1:0] rp[TO];
    logic [W-1:0] rn[TO];

    function automatic void model(output int kstar, output int kind, output logic [W-1:0] qexp);
        kstar = TO - 1;
        kind  = K_TMO;
        qexp  = '0;
        for (int k = 0; k < TO; k++) begin
            if ((rp[k] & rn[k]) != 0) begin
                kstar = k; kind = K_ILL; return;
            end
            if ((rp[k] ^ rn[k]) == 8'hFF && k >= EC - 1) begin
                kstar = k; kind = K_CAP; qexp = rp[k]; return;
            end
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kstar, kind, r, b;
        logic [W-1:0] qexp, base;
        logic [1:0]   exp_code;

        rst_n = 1'b0; req_in = 1'b0; ready_in = 1'b0;
        drive(8'h00, 8'h00);
        #12;
        chk("rst_pre",   32'(pre_out), 32'd1);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_q",     32'(q_out), 32'd0);
        chk("rst_err",   32'(err_out), 32'd0);
        chk("rst_code",  32'(err_code_out), 32'd0);
        chk("rst_busy",  32'(busy_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---- T2 normal capture, output held while ready low ----
        req_in = 1'b1; #1;
        chk("t2_ack_c0", 32'(req_ack_out), 32'd1);
        chk("t2_pre_c0", 32'(pre_out), 32'd1);
        step(); req_in = 1'b0;
        chk("t2_pre_c1",  32'(pre_out), 32'd0);
        chk("t2_busy_c1", 32'(busy_out), 32'd1);
        step();
        chk("t2_pre_c2",   32'(pre_out), 32'd0);
        chk("t2_valid_c2", 32'(valid_out), 32'd0);
        drive(8'hA5, 8'h5A);
        step();
        chk("t2_valid_c3", 32'(valid_out), 32'd1);
        chk("t2_q_c3",     32'(q_out), 32'hA5);
        chk("t2_pre_c3",   32'(pre_out), 32'd1);
        drive(8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_hold_valid", 32'(valid_out), 32'd1);
            chk("t2_hold_q",     32'(q_out), 32'hA5);
        end
        chk("t2_idle", 32'(busy_out), 32'd0);
        ready_in = 1'b1;
        step();
        chk("t2_valid_clr", 32'(valid_out), 32'd0);
        ready_in = 1'b0;

        // ---- T3 early completion in first EVAL cycle is ignored ----
        req_in = 1'b1; #1;
        chk("t3_ack", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        drive(8'h0F, 8'hF0);
        step();
        chk("t3_pre_c2",   32'(pre_out), 32'd0);
        chk("t3_valid_c2", 32'(valid_out), 32'd0);
        drive(8'h3C, 8'hC3);
        step();
        chk("t3_valid_c3", 32'(valid_out), 32'd1);
        chk("t3_q_c3",     32'(q_out), 32'h3C);
        drive(8'h00, 8'h00); ready_in = 1'b1;
        step();
        chk("t3_valid_clr", 32'(valid_out), 32'd0);
        chk("t3_idle",      32'(busy_out), 32'd0);
        ready_in = 1'b0;

        // ---- T4 illegal code during EVAL ----
        req_in = 1'b1; #1;
        chk("t4_ack", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        step();
        drive(8'hAD, 8'h5A);
        step();
        chk("t4_err",   32'(err_out), 32'd1);
        chk("t4_code",  32'(err_code_out), 32'd1);
        chk("t4_valid", 32'(valid_out), 32'd0);
        chk("t4_pre",   32'(pre_out), 32'd1);
        drive(8'h00, 8'h00);
        step();
        chk("t4_err_once", 32'(err_out), 32'd0);
        chk("t4_code_hold", 32'(err_code_out), 32'd1);
        chk("t4_idle", 32'(busy_out), 32'd0);

        // ---- T5 evaluation timeout ----
        req_in = 1'b1; #1;
        chk("t5_ack", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        drive(8'hA4, 8'h5A);
        for (int i = 0; i < TO - 1; i++) step();
        chk("t5_pre_last_eval", 32'(pre_out), 32'd0);
        chk("t5_no_err_yet",    32'(err_out), 32'd0);
        step();
        chk("t5_err",   32'(err_out), 32'd1);
        chk("t5_code",  32'(err_code_out), 32'd2);
        chk("t5_valid", 32'(valid_out), 32'd0);
        chk("t5_pre",   32'(pre_out), 32'd1);
        chk("t5_busy",  32'(busy_out), 32'd1);
        drive(8'h00, 8'h00);
        step();
        chk("t5_idle", 32'(busy_out), 32'd0);

        // ---- T6 precharge stall, then back-to-back requests ----
        req_in = 1'b1; #1;
        chk("t6_ack", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        step();
        drive(8'h96, 8'h69);
        step();                                  // c3
        chk("t6_valid", 32'(valid_out), 32'd1);
        chk("t6_q",     32'(q_out), 32'h96);
        step(); step();                          // c5
        req_in = 1'b1; #1;
        chk("t6_req_dropped", 32'(req_ack_out), 32'd0);
        step(); req_in = 1'b0;                   // c6
        step(); step();                          // c8
        chk("t6_no_err_yet", 32'(err_out), 32'd0);
        step();                                  // c9
        chk("t6_err",   32'(err_out), 32'd1);
        chk("t6_code",  32'(err_code_out), 32'd3);
        chk("t6_busy",  32'(busy_out), 32'd1);
        chk("t6_qhold", 32'(q_out), 32'h96);
        drive(8'h00, 8'h00);
        step();                                  // c10 IDLE
        chk("t6_idle", 32'(busy_out), 32'd0);
        req_in = 1'b1; ready_in = 1'b1; #1;
        chk("t6_ack2", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        chk("t6_valid_clr", 32'(valid_out), 32'd0);
        step();
        drive(8'h3C, 8'hC3);
        step();
        chk("t6_valid2", 32'(valid_out), 32'd1);
        chk("t6_q2",     32'(q_out), 32'h3C);
        drive(8'h00, 8'h00);
        step();
        req_in = 1'b1; #1;
        chk("t6_ack3", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        step();
        drive(8'hE1, 8'h1E);
        step();
        chk("t6_valid3", 32'(valid_out), 32'd1);
        chk("t6_q3",     32'(q_out), 32'hE1);
        chk("t6_code_hold", 32'(err_code_out), 32'd3);
        drive(8'h00, 8'h00);
        step();
        chk("t6_valid3_clr", 32'(valid_out), 32'd0);
        ready_in = 1'b0;
        exp_code = 2'b11;

        // ---- randomized transactions against the reference ----
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                b = $urandom_range(0, W - 1);
                base = '0;
                base[b] = 1'b1;
                drive(base, 8'h00);
                req_in = 1'b1; #1;
                chk("rnd_drop_ack", 32'(req_ack_out), 32'd0);
                step(); req_in = 1'b0;
                chk("rnd_drop_idle", 32'(busy_out), 32'd0);
                drive(8'h00, 8'h00);
            end
            for (int k = 0; k < TO; k++) begin
                r = $urandom_range(0, 9);
                base = 8'($urandom);
                rp[k] = base;
                rn[k] = ~base;
                b = $urandom_range(0, W - 1);
                if (r == 0) begin
                    rp[k][b] = 1'b1; rn[k][b] = 1'b1;
                end else if (r >= 5) begin
                    rp[k][b] = 1'b0; rn[k][b] = 1'b0;
                end
            end
            model(kstar, kind, qexp);
            req_in = 1'b1; #1;
            chk("rnd_ack", 32'(req_ack_out), 32'd1);
            step(); req_in = 1'b0;
            for (int k = 0; k <= kstar; k++) begin
                chk("rnd_pre_eval", 32'(pre_out), 32'd0);
                drive(rp[k], rn[k]);
                step();
            end
            chk("rnd_pre_done", 32'(pre_out), 32'd1);
            chk("rnd_busy",     32'(busy_out), 32'd1);
            if (kind == K_CAP) begin
                chk("rnd_valid", 32'(valid_out), 32'd1);
                chk("rnd_q",     32'(q_out), 32'(qexp));
                chk("rnd_noerr", 32'(err_out), 32'd0);
            end else begin
                exp_code = (kind == K_ILL) ? 2'b01 : 2'b10;
                chk("rnd_err",     32'(err_out), 32'd1);
                chk("rnd_novalid", 32'(valid_out), 32'd0);
            end
            chk("rnd_code", 32'(err_code_out), 32'(exp_code));
            drive(8'h00, 8'h00); ready_in = 1'b1;
            step();
            chk("rnd_idle",      32'(busy_out), 32'd0);
            chk("rnd_valid_clr", 32'(valid_out), 32'd0);
            chk("rnd_err_once",  32'(err_out), 32'd0);
            ready_in = 1'b0;
        end

        // ---- T1 reset while evaluating ----
        drive(8'h00, 8'h00);
        ready_in = 1'b1; step();
        drive(8'h5A, 8'hA5);
        step();
        ready_in = 1'b0;
        drive(8'h00, 8'h00);
        step();
        req_in = 1'b1; #1;
        chk("t1_ack", 32'(req_ack_out), 32'd1);
        step(); req_in = 1'b0;
        chk("t1_pre_eval", 32'(pre_out), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_pre",   32'(pre_out), 32'd1);
        chk("t1_valid", 32'(valid_out), 32'd0);
        chk("t1_q",     32'(q_out), 32'd0);
        chk("t1_code",  32'(err_code_out), 32'd0);
        chk("t1_busy",  32'(busy_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_after_pre", 32'(pre_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
